// File: rtl/dmem_burst_adapter_pkg.sv
// dmem_burst_adapter_pkg: shared types and constants for the word-to-burst memory adapter
package burst_adapter_types;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} badapt_state_t;
    localparam int BEAT_W = 64;
    localparam int DEF_LINE_BEATS = 4;
    typedef logic [DEF_LINE_BEATS*BEAT_W-1:0] line_t;
endpackage

// File: rtl/dmem_burst_adapter_line_merge.sv
// line_merge: selects one 32-bit word of a line and builds the byte-masked merged line
//   line   : in  full line (LINE_BEATS*64 bits)
//   idx    : in  word index within the line
//   wmask  : in  byte enables of the write
//   wdata  : in  write data
//   merged : out line with the selected word's enabled bytes replaced by wdata
//   word   : out selected word of the unmodified line
module line_merge
    import burst_adapter_types::*;
#(
    parameter int LINE_BEATS = DEF_LINE_BEATS
) (
    input  logic [LINE_BEATS*BEAT_W-1:0]     line,
    input  logic [$clog2(2*LINE_BEATS)-1:0]  idx,
    input  logic [3:0]                       wmask,
    input  logic [31:0]                      wdata,
    output logic [LINE_BEATS*BEAT_W-1:0]     merged,
    output logic [31:0]                      word
);
    assign word = line[idx*32 +: 32];
    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++)
            if (wmask[b]) merged[idx*32 + 8*b +: 8] = wdata[8*b +: 8];
    end
endmodule

// File: rtl/dmem_burst_adapter.sv
// dmem_burst_adapter: answers 32-bit CPU word requests with 64-bit line bursts (read-modify-write for stores)
//   clk, rst (async, active-high)
//   mem_address/mem_read/mem_write/mem_wmask/mem_wdata : CPU request, held until mem_resp
//   mem_rdata/mem_resp                                : CPU response, mem_resp is a one-cycle pulse
//   bmem_address/bmem_read/bmem_write/bmem_wdata      : burst request, strobes held for the whole burst
//   bmem_rdata/bmem_resp                              : burst beat data / beat handshake
// Optional DMEM_LINE_BUF_EN keeps the last line as a write-through buffer so repeat accesses skip the read burst.
module dmem_burst_adapter
    import burst_adapter_types::*;
#(
    parameter int LINE_BEATS = DEF_LINE_BEATS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [31:0] bmem_address,
    output logic        bmem_read,
    output logic        bmem_write,
    input  logic [63:0] bmem_rdata,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_resp
);
    localparam int OFS = $clog2(8*LINE_BEATS);
    localparam int CW  = $clog2(LINE_BEATS);
    localparam int LW  = LINE_BEATS*BEAT_W;

    badapt_state_t state, state_next;
    logic [31:0]   addr, wdata, wdata_sel, word;
    logic [3:0]    wmask, wmask_sel;
    logic          is_write, hit, last, unused;
    logic [CW-1:0] cnt;
    logic [LW-1:0] line, line_in, merged;
    logic [OFS-3:0] idx;

    assign last = cnt == CW'(LINE_BEATS-1);
    // In IDLE the merge/select work on the live request so buffer hits answer without latching first.
    assign idx       = state == IDLE ? mem_address[OFS-1:2] : addr[OFS-1:2];
    assign wmask_sel = state == IDLE ? mem_wmask : wmask;
    assign wdata_sel = state == IDLE ? mem_wdata : wdata;

    // Line including the beat arriving this cycle, so the last beat merges without an extra cycle.
    always_comb begin
        line_in = line;
        if (state == RD_BURST && bmem_resp) line_in[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    line_merge #(.LINE_BEATS(LINE_BEATS)) u_merge (
        .line   (line_in),
        .idx    (idx),
        .wmask  (wmask_sel),
        .wdata  (wdata_sel),
        .merged (merged),
        .word   (word)
    );

`ifdef DMEM_LINE_BUF_EN
    logic              valid;
    logic [31-OFS:0]   tag;
    assign hit = valid && tag == mem_address[31:OFS];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
        end else begin
            if (state == IDLE && (mem_read || mem_write) && !hit) begin
                valid <= 1'b0;
                tag   <= mem_address[31:OFS];
            end
            if (state == RD_BURST && bmem_resp && last) valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mem_write)     state_next = hit ? WR_BURST : RD_BURST;
                      else if (mem_read) state_next = hit ? RESP : RD_BURST;
            RD_BURST: if (bmem_resp && last) state_next = is_write ? WR_BURST : RESP;
            WR_BURST: if (bmem_resp && last) state_next = RESP;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            wmask     <= '0;
            wdata     <= '0;
            is_write  <= 1'b0;
            cnt       <= '0;
            line      <= '0;
            mem_rdata <= '0;
        end else begin
            if (state == IDLE && (mem_read || mem_write)) begin
                addr     <= mem_address;
                wmask    <= mem_wmask;
                wdata    <= mem_wdata;
                is_write <= mem_write;
                cnt      <= '0;
            end
            if ((state == RD_BURST || state == WR_BURST) && bmem_resp) cnt <= cnt + 1'b1;
            if (state == RD_BURST && bmem_resp) line <= (last && is_write) ? merged : line_in;
            if (state == IDLE && mem_write && hit) line <= merged;
            if (state_next == RESP) mem_rdata <= word;
        end
    end

    assign mem_resp     = state == RESP;
    assign bmem_read    = state == RD_BURST;
    assign bmem_write   = state == WR_BURST;
    assign bmem_address = {addr[31:OFS], {OFS{1'b0}}};
    assign bmem_wdata   = bmem_write ? line[cnt*BEAT_W +: BEAT_W] : '0;
    assign unused       = ^{mem_address[1:0], addr[1:0]};
endmodule

// File: tb/tb_dmem_burst_adapter.sv
// tb_dmem_burst_adapter: randomized scoreboard bench with word-level reference model and beat-level memory
module tb_dmem_burst_adapter;
    localparam int L = 4;
    localparam logic [31:0] LMASK = ~(32'(8*L) - 32'd1);

    logic        clk, rst;
    logic [31:0] mem_address, mem_wdata, mem_rdata, bmem_address;
    logic        mem_read, mem_write, mem_resp, bmem_read, bmem_write, bmem_resp;
    logic [3:0]  mem_wmask;
    logic [63:0] bmem_rdata, bmem_wdata;

    dmem_burst_adapter #(.LINE_BEATS(L)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_rdata(bmem_rdata), .bmem_wdata(bmem_wdata), .bmem_resp(bmem_resp)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          lat;
        int          rdb;
        int          wrb;
        int          issue;
    } exp_t;

    exp_t        sbq[$];
    exp_t        me;
    logic [63:0] bmem [logic [31:0]];
    logic [31:0] refw [logic [31:0]];
    logic [31:0] touched[$];
    int tests = 0, fails = 0, cyc = 0, resp_cnt = 0, rd_beats = 0, wr_beats = 0;
    int gap_lo = 0, gap_hi = 0;
    bit spur = 0, buf_valid = 0, prev_resp = 0;
    logic [31:0] buf_line = 0, exp_line = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [63:0] init_beat(logic [31:0] a);
        return {a ^ 32'hC0DE_0000, ~a + 32'h1234_5678};
    endfunction

    function automatic logic [63:0] mget(logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : init_beat(a);
    endfunction

    function automatic logic [31:0] pick(logic [63:0] b, logic hi);
        return hi ? b[63:32] : b[31:0];
    endfunction

    function automatic logic [31:0] rget(logic [31:0] wa);
        return refw.exists(wa) ? refw[wa] : pick(init_beat({wa[31:3], 3'b000}), wa[2]);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] wa, w, line;
        bit seen;
        wa = {a[31:2], 2'b00};
        w  = rget(wa);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        refw[wa] = w;
        line = a & LMASK;
        seen = 0;
        foreach (touched[i]) if (touched[i] == line) seen = 1;
        if (!seen) touched.push_back(line);
    endtask

    task automatic summary_and_finish();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Burst memory: decides each beat at the falling edge; the DUT takes it on the next rising edge.
    initial begin
        int k, gcnt;
        logic [31:0] a;
        k = 0; gcnt = 0;
        bmem_resp = 0; bmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = 0; gcnt = 0; bmem_resp = 0;
            end else if (bmem_read || bmem_write) begin
                if (gcnt > 0) begin
                    gcnt--;
                    bmem_resp = 0;
                    bmem_rdata = {$urandom, $urandom};
                end else begin
                    gcnt = int'($urandom_range(gap_hi, gap_lo));
                    bmem_resp = 1;
                    chk("bmem_address", bmem_address, exp_line);
                    a = bmem_address + 32'(8*k);
                    if (bmem_read) begin
                        bmem_rdata = mget(a);
                        rd_beats++;
                    end else begin
                        bmem[a] = bmem_wdata;
                        wr_beats++;
                    end
                    k = (k + 1) % L;
                end
            end else begin
                gcnt = 0;
                bmem_resp = spur && ($urandom_range(0, 3) == 0);
                bmem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("strobe_exclusive", 64'(bmem_read & bmem_write), 64'd0);
                if (mem_resp) begin
                    chk("resp_single_pulse", 64'(prev_resp), 64'd0);
                    if (sbq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_resp: got mem_resp=1 expected no pending request (cycle %0d)", cyc);
                    end else begin
                        me = sbq.pop_front();
                        if (!me.is_wr) chk("rdata", 64'(mem_rdata), 64'(me.data));
                        if (me.lat >= 0) chk("resp_latency", 64'(cyc - me.issue), 64'(me.lat));
                        chk("read_beats", 64'(rd_beats), 64'(me.rdb));
                        chk("write_beats", 64'(wr_beats), 64'(me.wrb));
                    end
                    resp_cnt++;
                end
            end
            prev_resp = mem_resp;
        end
    end

    // Issues one request at (posedge+1) and returns at (posedge+1) after its response.
    task automatic req(input bit we, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       input bit both, input bit scr);
        exp_t e;
        logic [31:0] line;
        bit hit;
        int t, start;
        line = a & LMASK;
`ifdef DMEM_LINE_BUF_EN
        hit = buf_valid && buf_line == line;
`else
        hit = 0;
`endif
        e.is_wr = we;
        e.data  = we ? 32'h0 : rget({a[31:2], 2'b00});
        if (we) ref_write(a, m, d);
        e.rdb   = hit ? 0 : L;
        e.wrb   = we ? L : 0;
        e.lat   = gap_hi == 0 ? e.rdb + e.wrb + 1 : -1;
        e.issue = cyc;
        buf_valid = 1; buf_line = line; exp_line = line;
        rd_beats = 0; wr_beats = 0;
        sbq.push_back(e);
        mem_address = a; mem_write = we; mem_read = !we || both; mem_wmask = m; mem_wdata = d;
        start = resp_cnt; t = 0;
        while (resp_cnt == start && t < 2000) begin
            @(posedge clk); #1; t++;
            if (scr && resp_cnt == start) begin
                mem_address = $urandom; mem_wmask = 4'($urandom); mem_wdata = $urandom;
            end
        end
        if (resp_cnt == start) begin
            tests++; fails++;
            $display("FAIL resp_timeout: got no mem_resp after %0d cycles expected one for addr %h", t, a);
            summary_and_finish();
        end
        mem_read = 0; mem_write = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
        chk({tag, "_mem_rdata"}, 64'(mem_rdata), 64'd0);
        chk({tag, "_bmem_read"}, 64'(bmem_read), 64'd0);
        chk({tag, "_bmem_write"}, 64'(bmem_write), 64'd0);
        chk({tag, "_bmem_address"}, 64'(bmem_address), 64'd0);
        chk({tag, "_bmem_wdata"}, bmem_wdata, 64'd0);
    endtask

    task automatic reset_mid_burst();
        int t;
        gap_lo = 0; gap_hi = 0;
        exp_line = 32'h300; rd_beats = 0; wr_beats = 0;
        mem_address = 32'h300; mem_read = 1;
        t = 0;
        while (rd_beats < 2 && t < 100) begin @(negedge clk); t++; end
        chk("midreset_reached_beat2", 64'(rd_beats >= 2), 64'd1);
        #2 rst = 1;
        #1 check_reset_outputs("midreset");
        mem_read = 0;
        buf_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] a, wa;
        bit we, both;
        pool = '{32'h40, 32'h100, 32'h200, 32'h1000, 32'hFFFF_FFE0, 32'h8000_0000};
        rst = 0; mem_address = 0; mem_read = 0; mem_write = 0; mem_wmask = 0; mem_wdata = 0;
        #2 rst = 1;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 0;

        req(0, 32'h44, 4'h0, 32'h0, 0, 0);
        req(1, 32'h44, 4'b0110, 32'hAABB_CCDD, 0, 0);
        req(0, 32'h44, 4'h0, 32'h0, 0, 0);

        gap_lo = 3; gap_hi = 3;
        req(0, 32'h80, 4'h0, 32'h0, 0, 0);
        req(1, 32'h84, 4'b1001, 32'h1234_5678, 0, 0);
        req(0, 32'h84, 4'h0, 32'h0, 0, 0);
        gap_lo = 0; gap_hi = 0;

        req(0, 32'h100, 4'h0, 32'h0, 0, 0);
        req(1, 32'h200, 4'hF, 32'hDEAD_BEEF, 0, 0);
        req(1, 32'h204, 4'b0011, 32'hCAFE_F00D, 1, 0);
        req(0, 32'h204, 4'h0, 32'h0, 0, 0);
        req(0, 32'h200, 4'h0, 32'h0, 0, 0);

        req(1, 32'h48, 4'b1100, 32'h5566_7788, 0, 0);
        req(0, 32'h48, 4'h0, 32'h0, 0, 0);

        reset_mid_burst();
        req(0, 32'h300, 4'h0, 32'h0, 0, 0);

        spur = 1;
        for (int i = 0; i < 80; i++) begin
            a = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 8*L-1));
            both = $urandom_range(0, 7) == 0;
            we = both || $urandom_range(0, 1) == 1;
            gap_lo = 0; gap_hi = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            req(we, a, 4'($urandom), $urandom, both, 1);
        end
        spur = 0;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        foreach (touched[i])
            for (int w = 0; w < 2*L; w++) begin
                wa = touched[i] + 32'(4*w);
                chk("memory_word", 64'(pick(mget({wa[31:3], 3'b000}), wa[2])), 64'(rget(wa)));
            end
        summary_and_finish();
    end
endmodule
